// File: rtl/mode_sequencer.sv
// Mode sequencer: cycles PLAY / LIVE / RECORD on debounced next/prev pulses,
// selects the key source for each mode, and captures switch changes into a
// record buffer while in RECORD. Writes are registered, one clock after the
// qualifying edge, and stop when the buffer is full.
//
// state  | meaning
// -------+---------------------------------------------------------
// PLAY   | playback decoder drives keys, tempo adjust enabled
// LIVE   | live switches drive keys
// RECORD | live switches drive keys, each distinct value is captured
module mode_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_next,
  input  logic             mode_prev,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH-1:0] play_data,
  output logic [1:0]       mode,
  output logic             music_box,
  output logic             electone,
  output logic             writing,
  output logic             adj,
  output logic [WIDTH-1:0] key_out,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [AW:0]      rec_len,
  output logic             rec_full
);

  typedef enum logic [1:0] {
    MODE_PLAY   = 2'd0,
    MODE_LIVE   = 2'd1,
    MODE_RECORD = 2'd2
  } mode_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  mode_e            mode_q, mode_d;
  logic [AW:0]      ptr_q, ptr_d;
  logic [WIDTH-1:0] last_sw_q, last_sw_d;
  logic             first_pending_q, first_pending_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic step_fwd;
  logic step_back;
  logic enter_rec;
  logic capture;

  assign step_fwd  = mode_next & ~mode_prev;
  assign step_back = mode_prev & ~mode_next;

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_PLAY;
    else        mode_q <= mode_d;
  end

  // Next mode: forward/backward ring, simultaneous pulses ignored.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_PLAY: begin
        if (step_fwd)       mode_d = MODE_LIVE;
        else if (step_back) mode_d = MODE_RECORD;
      end
      MODE_LIVE: begin
        if (step_fwd)       mode_d = MODE_RECORD;
        else if (step_back) mode_d = MODE_PLAY;
      end
      MODE_RECORD: begin
        if (step_fwd)       mode_d = MODE_PLAY;
        else if (step_back) mode_d = MODE_LIVE;
      end
      default: mode_d = MODE_PLAY;
    endcase
  end

  // One-hot mode flags and key source selection.
  always_comb begin
    music_box = 1'b0;
    electone  = 1'b0;
    writing   = 1'b0;
    adj       = 1'b0;
    key_out   = sw;
    case (mode_q)
      MODE_PLAY: begin
        music_box = 1'b1;
        adj       = 1'b1;
        key_out   = play_data;
      end
      MODE_LIVE:   electone = 1'b1;
      MODE_RECORD: writing  = 1'b1;
      default: begin
        music_box = 1'b0;
        key_out   = sw;
      end
    endcase
  end

  // Capture decision uses the pre-edge mode so a write that coincides with
  // leaving RECORD still lands. Entering RECORD only rearms the recorder.
  assign enter_rec = (mode_d == MODE_RECORD) && (mode_q != MODE_RECORD);
  assign capture   = (mode_q == MODE_RECORD) && (ptr_q < DEPTH_C) &&
                     (first_pending_q || (sw != last_sw_q));

  // Recorder next-state: write strobe, pointer and last-captured value.
  always_comb begin
    ptr_d           = ptr_q;
    last_sw_d       = last_sw_q;
    first_pending_d = first_pending_q;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    if (capture) begin
      wr_en_d         = 1'b1;
      wr_addr_d       = ptr_q[AW-1:0];
      wr_data_d       = sw;
      ptr_d           = ptr_q + ONE_C;
      last_sw_d       = sw;
      first_pending_d = 1'b0;
    end else if (enter_rec) begin
      ptr_d           = '0;
      first_pending_d = 1'b1;
    end
  end

  // Recorder registers; reset aborts any recording in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q           <= '0;
      last_sw_q       <= '0;
      first_pending_q <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
    end else begin
      ptr_q           <= ptr_d;
      last_sw_q       <= last_sw_d;
      first_pending_q <= first_pending_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
    end
  end

  assign mode     = mode_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rec_len  = ptr_q;
  assign rec_full = (ptr_q == DEPTH_C);

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios followed by random traffic,
// compared against a behavioural model. Expected record writes go into a
// queue that an independent monitor drains whenever wr_en is seen.
module tb_mode_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode_next = 1'b0;
  logic             mode_prev = 1'b0;
  logic [WIDTH-1:0] sw = '0;
  logic [WIDTH-1:0] play_data = '0;
  logic [1:0]       mode;
  logic             music_box, electone, writing, adj;
  logic [WIDTH-1:0] key_out;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW:0]      rec_len;
  logic             rec_full;

  mode_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mode_next(mode_next), .mode_prev(mode_prev),
    .sw(sw), .play_data(play_data), .mode(mode), .music_box(music_box),
    .electone(electone), .writing(writing), .adj(adj), .key_out(key_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rec_len(rec_len), .rec_full(rec_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode as 0/1/2 ring, recorder as count + last value.
  int          m_mode  = 0;
  int          m_count = 0;
  int          m_last  = 0;
  bit          m_first = 1'b0;
  logic [31:0] exp_q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endfunction

  function automatic void model_edge(bit n, bit p, int s);
    int nxt;
    if (m_mode == 2 && m_count < DEPTH && (m_first || s != m_last)) begin
      exp_q.push_back({16'(m_count), 16'(s)});
      m_count++;
      m_last  = s;
      m_first = 1'b0;
    end
    nxt = m_mode;
    if (n && !p) nxt = (m_mode + 1) % 3;
    if (p && !n) nxt = (m_mode + 2) % 3;
    if (nxt == 2 && m_mode != 2) begin
      m_count = 0;
      m_first = 1'b1;
    end
    m_mode = nxt;
  endfunction

  function automatic void check_outputs(string tag);
    chk({tag, "_mode"},      32'(mode),      32'(m_mode));
    chk({tag, "_music_box"}, 32'(music_box), 32'(m_mode == 0));
    chk({tag, "_adj"},       32'(adj),       32'(m_mode == 0));
    chk({tag, "_electone"},  32'(electone),  32'(m_mode == 1));
    chk({tag, "_writing"},   32'(writing),   32'(m_mode == 2));
    chk({tag, "_key_out"},   32'(key_out),   32'(m_mode == 0 ? play_data : sw));
    chk({tag, "_rec_len"},   32'(rec_len),   32'(m_count));
    chk({tag, "_rec_full"},  32'(rec_full),  32'(m_count == DEPTH));
  endfunction

  task automatic step(input bit n, input bit p, input int s, input int pd);
    @(negedge clk);
    mode_next = n;
    mode_prev = p;
    sw        = WIDTH'(s);
    play_data = WIDTH'(pd);
    #1;
    check_outputs("step");
    model_edge(n, p, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    mode_next = 1'b0;
    mode_prev = 1'b0;
    m_mode  = 0;
    m_count = 0;
    m_last  = 0;
    m_first = 1'b0;
    #1;
    check_outputs("reset");
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every observed write must match the oldest expected write.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && wr_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h required no write",
                   wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e[31:16]));
          chk("wr_data", 32'(wr_data), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    int r;
    int s;
    do_reset();

    // Mode ring forward, then backward wrap and simultaneous pulses.
    repeat (4) step(1, 0, 0, 16'h1234);
    step(0, 0, 0, 16'h00f0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 16'h0042, 0);
    step(0, 0, 16'h0042, 0);

    // Record 0001,0001,0003,0003,0080 after entering with 0001.
    step(1, 0, 16'h0001, 0);
    step(1, 0, 16'h0001, 0);
    step(1, 0, 16'h0001, 0);
    step(0, 0, 16'h0001, 0);
    step(0, 0, 16'h0003, 0);
    step(0, 0, 16'h0003, 0);
    step(0, 0, 16'h0080, 0);
    step(0, 0, 16'h0080, 0);
    step(0, 0, 16'h0080, 0);

    // Fill the buffer with a value that changes every cycle.
    step(1, 0, 16'h0080, 0);
    step(0, 1, 16'h0080, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0100 + i, 0);
    step(0, 0, 16'h0aaa, 0);

    // Leave RECORD on the same edge as a captured change.
    step(1, 0, 16'h0aaa, 0);
    step(0, 1, 16'h0005, 0);
    step(0, 0, 16'h0005, 0);
    step(1, 0, 16'h0009, 0);
    step(0, 0, 16'h0011, 16'h0777);
    step(0, 0, 16'h0022, 16'h0777);

    // Reset in the middle of a recording.
    step(0, 1, 16'h0033, 0);
    step(0, 0, 16'h0044, 0);
    do_reset();
    step(0, 0, 16'h0055, 16'h0abc);
    step(0, 0, 16'h0066, 16'h0abc);

    // Random traffic.
    s = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      r = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) s = int'($urandom_range(0, 3));
      step(r == 0 || r == 1 || r == 3, r == 2 || r == 3, s,
           int'($urandom_range(0, 65535)));
    end

    repeat (3) step(0, 0, s, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, width of switch/play data and write data.
REQ-002 SHALL have parameter DEPTH, default 64, record buffer entries; AW = clog2(DEPTH), minimum DEPTH 2.
REQ-003 SHALL have ports: clk input 1, system clock; rst_n input 1, reset asynchronous, active-low.
REQ-004 SHALL have ports: mode_next input 1, one-cycle debounced pulse; mode_prev input 1, one-cycle debounced pulse.
REQ-005 SHALL have ports: sw input WIDTH, live switch keys; play_data input WIDTH, playback decoder keys.
REQ-006 SHALL have ports: mode output 2, current mode; music_box, electone, writing outputs 1, one-hot mode flags; adj output 1, tempo-adjust enable.
REQ-007 SHALL have ports: key_out output WIDTH, selected key vector; wr_en output 1; wr_addr output AW; wr_data output WIDTH.
REQ-008 SHALL have ports: rec_len output AW+1, entries written; rec_full output 1, buffer full.

Function
REQ-009 SHALL hold mode in a register: 0 PLAY, 1 LIVE, 2 RECORD; encoding 3 never reached.
REQ-010 SHALL, on a clk edge with mode_next=1 and mode_prev=0, advance PLAY->LIVE->RECORD->PLAY (wrap 2->0).
REQ-011 SHALL, on a clk edge with mode_prev=1 and mode_next=0, step back PLAY->RECORD->LIVE->PLAY (wrap 0->2).
REQ-012 SHALL ignore simultaneous mode_next and mode_prev; mode unchanged.
REQ-013 SHALL decode flags combinationally from mode with full case and no latches: PLAY music_box=1, adj=1; LIVE electone=1; RECORD writing=1; all other flags 0.
REQ-014 SHALL drive key_out = play_data in PLAY, sw in LIVE and RECORD, combinationally.
REQ-015 SHALL keep a write pointer ptr (AW+1 bits), a last-captured register last_sw (WIDTH), and a first_pending flag.
REQ-016 SHALL, on the edge that enters RECORD, clear ptr to 0, set first_pending=1, and perform no write.
REQ-017 SHALL, on any edge where current mode is RECORD, ptr<DEPTH, and (first_pending=1 or sw!=last_sw), register wr_en=1, wr_data=sw, wr_addr=ptr[AW-1:0], then ptr+=1, last_sw=sw, first_pending=0.
REQ-018 SHALL otherwise register wr_en=0; wr_en is high for exactly one cycle per captured entry; wr_addr/wr_data hold their last values when wr_en=0.
REQ-019 SHALL evaluate write condition using the pre-edge mode: a change leaving RECORD on the same edge as a qualifying sw change still writes that entry.
REQ-020 SHALL drive rec_len = ptr and rec_full = (ptr == DEPTH); at full, further sw changes are dropped with no pointer wrap.
REQ-021 SHALL retain ptr, rec_len and rec_full after leaving RECORD until RECORD is next entered.
REQ-022 SHALL produce write latency of one clock: sw change visible at edge k -> wr_en high during cycle after edge k.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force mode=0 (PLAY), ptr=0, last_sw=0, first_pending=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-024 SHALL therefore present music_box=1, adj=1, electone=0, writing=0, key_out=play_data, rec_len=0, rec_full=0 during and after reset.
REQ-025 SHALL abort a recording on reset mid-RECORD, with no wr_en pulse in the reset-release cycle.

Verification
REQ-026 SHALL cover reset then four mode_next pulses -> mode sequence 0,1,2,0,1, one-hot flags matching each.
REQ-027 SHALL cover mode_prev from PLAY -> mode=2, writing=1; mode_next+mode_prev same cycle -> mode unchanged.
REQ-028 SHALL cover enter RECORD with sw=16'h0001, then sw 16'h0001,16'h0003,16'h0003,16'h0080 -> writes (addr0,0001),(addr1,0003),(addr2,0080), rec_len=3.
REQ-029 SHALL cover DEPTH=4, sw toggling every cycle in RECORD -> exactly 4 writes addr 0..3, rec_full=1, no 5th wr_en.
REQ-030 SHALL cover mode_next coinciding with sw change in RECORD -> that entry written, mode=PLAY next cycle, rec_len retained; rst_n low mid-RECORD -> mode=0, rec_len=0, wr_en=0.
